// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: 10G MAC TX control FSM (preamble, data, pad, FCS, term, IFG).
// Build option TX_AUTO_PAD_EN: pad short frames; when undefined short frames abort.
module tx_frame_sequencer #(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int MAX_FRAME_BYTES = 1514,
    parameter int IFG_CYCLES      = 2
) (
    input  logic        txclk,
    input  logic        reset,
    input  logic        tx_enable,
    input  logic        tx_start,
    input  logic [7:0]  tx_data_valid,
    input  logic        tx_eop,
    output logic        tx_ack,
    output logic        send_preamble,
    output logic        send_data,
    output logic        send_pad,
    output logic        send_fcs,
    output logic        send_term,
    output logic        send_error,
    output logic [13:0] frame_len,
    output logic        good_frame_sent,
    output logic        bad_frame_sent
);

    typedef enum logic [7:0] {
        IDLE = 8'b0000_0001,
        PRE  = 8'b0000_0010,
        DATA = 8'b0000_0100,
        PAD  = 8'b0000_1000,
        FCS  = 8'b0001_0000,
        TERM = 8'b0010_0000,
        ERR  = 8'b0100_0000,
        IFG  = 8'b1000_0000
    } state_t;

    localparam logic [13:0] MIN_LEN  = 14'(MIN_FRAME_BYTES);
    localparam logic [13:0] MAX_LEN  = 14'(MAX_FRAME_BYTES);
    localparam logic [7:0]  IFG_LOAD = 8'(IFG_CYCLES);
    // The IDLE cycle that samples tx_start is itself the last gap cycle.
    localparam state_t      GAP_NEXT = (IFG_CYCLES > 1) ? IFG : IDLE;

    state_t      state;
    logic [7:0]  ifg_cnt;
    logic [3:0]  lane_cnt;
    logic [14:0] data_sum;
    logic [13:0] data_len;

    always_comb begin
        lane_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            lane_cnt = lane_cnt + {3'd0, tx_data_valid[i]};
        end
    end

    assign data_sum = {1'b0, frame_len} + {11'd0, lane_cnt};
    assign data_len = data_sum[14] ? 14'h3FFF : data_sum[13:0];

`ifdef TX_AUTO_PAD_EN
    logic [13:0] pad_gap;
    logic [13:0] pad_len;

    always_comb begin
        pad_gap = MIN_LEN - frame_len;
        pad_len = (pad_gap > 14'd8) ? frame_len + 14'd8 : MIN_LEN;
    end
`endif

    always_ff @(posedge txclk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            frame_len       <= 14'd0;
            ifg_cnt         <= 8'd0;
            tx_ack          <= 1'b0;
            good_frame_sent <= 1'b0;
            bad_frame_sent  <= 1'b0;
        end else begin
            tx_ack          <= 1'b0;
            good_frame_sent <= 1'b0;
            bad_frame_sent  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ifg_cnt != 8'd0) begin
                        ifg_cnt <= ifg_cnt - 8'd1;
                    end
                    if (tx_start && tx_enable) begin
                        state     <= PRE;
                        tx_ack    <= 1'b1;
                        frame_len <= 14'd0;
                    end
                end
                PRE: begin
                    state <= DATA;
                end
                DATA: begin
                    frame_len <= data_len;
                    if (tx_data_valid == 8'h00) begin
                        state <= ERR;
                    end else if (data_len > MAX_LEN) begin
                        state <= ERR;
                    end else if (tx_eop && (data_len < MIN_LEN)) begin
`ifdef TX_AUTO_PAD_EN
                        state <= PAD;
`else
                        state <= ERR;
`endif
                    end else if (tx_eop) begin
                        state <= FCS;
                    end
                end
`ifdef TX_AUTO_PAD_EN
                PAD: begin
                    frame_len <= pad_len;
                    if (pad_len == MIN_LEN) begin
                        state <= FCS;
                    end
                end
`endif
                FCS: begin
                    state <= TERM;
                end
                TERM: begin
                    good_frame_sent <= 1'b1;
                    ifg_cnt         <= IFG_LOAD;
                    state           <= GAP_NEXT;
                end
                ERR: begin
                    bad_frame_sent <= 1'b1;
                    ifg_cnt        <= IFG_LOAD;
                    state          <= GAP_NEXT;
                end
                IFG: begin
                    ifg_cnt <= ifg_cnt - 8'd1;
                    if (ifg_cnt <= 8'd2) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign send_preamble = (state == PRE);
    assign send_data     = (state == DATA);
    assign send_fcs      = (state == FCS);
    assign send_term     = (state == TERM);
    assign send_error    = (state == ERR);
`ifdef TX_AUTO_PAD_EN
    assign send_pad      = (state == PAD);
`else
    assign send_pad      = 1'b0;
`endif

    onehot_state_a: assert property (
        @(posedge txclk) disable iff (reset) $onehot(state)
    );

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb_tx_frame_sequencer: random and directed frames against a frame-level model.
// The model follows TX_AUTO_PAD_EN, so either build can be checked.
module tb_tx_frame_sequencer;

    localparam int MIN_B = 60;
    localparam int MAX_B = 1514;
    localparam int IFG   = 2;
`ifdef TX_AUTO_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic        txclk = 1'b0;
    logic        reset;
    logic        tx_enable;
    logic        tx_start;
    logic [7:0]  tx_data_valid;
    logic        tx_eop;
    logic        tx_ack;
    logic        send_preamble;
    logic        send_data;
    logic        send_pad;
    logic        send_fcs;
    logic        send_term;
    logic        send_error;
    logic [13:0] frame_len;
    logic        good_frame_sent;
    logic        bad_frame_sent;

    always #5 txclk = ~txclk;

    tx_frame_sequencer #(
        .MIN_FRAME_BYTES(MIN_B),
        .MAX_FRAME_BYTES(MAX_B),
        .IFG_CYCLES     (IFG)
    ) dut (
        .txclk          (txclk),
        .reset          (reset),
        .tx_enable      (tx_enable),
        .tx_start       (tx_start),
        .tx_data_valid  (tx_data_valid),
        .tx_eop         (tx_eop),
        .tx_ack         (tx_ack),
        .send_preamble  (send_preamble),
        .send_data      (send_data),
        .send_pad       (send_pad),
        .send_fcs       (send_fcs),
        .send_term      (send_term),
        .send_error     (send_error),
        .frame_len      (frame_len),
        .good_frame_sent(good_frame_sent),
        .bad_frame_sent (bad_frame_sent)
    );

    typedef struct packed {
        logic       start;
        logic       enable;
        logic [7:0] valid;
        logic       eop;
    } stim_t;

    typedef struct packed {
        logic        ack;
        logic        pre;
        logic        dat;
        logic        pad;
        logic        fcs;
        logic        term;
        logic        err;
        logic        good;
        logic        bad;
        logic [13:0] len;
    } exp_t;

    logic [22:0] obs_now;
    assign obs_now = {tx_ack, send_preamble, send_data, send_pad, send_fcs,
                      send_term, send_error, good_frame_sent, bad_frame_sent,
                      frame_len};

    stim_t       sq[$];
    exp_t        eq[$];
    logic [8:0]  words[$];
    int          pending;
    logic [13:0] prev_len;
    bit          after_end;
    int          checks;
    int          errors;
    int          cyc;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic stim_t rnd_stim(input logic start, input logic enable);
        stim_t s;
        s.start  = start;
        s.enable = enable;
        s.valid  = 8'($urandom);
        s.eop    = 1'($urandom);
        return s;
    endfunction

    function automatic exp_t quiet();
        exp_t e;
        e     = '0;
        e.len = prev_len;
        return e;
    endfunction

    function automatic void push(input stim_t s, input exp_t e);
        if (pending == 1) e.good = 1'b1;
        if (pending == 2) e.bad = 1'b1;
        pending = 0;
        sq.push_back(s);
        eq.push_back(e);
    endfunction

    // Client words as {eop, lane_valid}; full words then one partial word.
    function automatic void gen_words(input int nbytes, input bit eop_last);
        words.delete();
        for (int b = nbytes; b > 0; b -= 8) begin
            int k;
            k = (b >= 8) ? 8 : b;
            words.push_back({1'b0, 8'((1 << k) - 1)});
        end
        if (eop_last) begin
            words[words.size() - 1] = words[words.size() - 1] | 9'h100;
        end
    endfunction

    // Expected cycle trace of one frame, derived from the frame-level rules.
    function automatic void add_frame(input int n_idle, input bit hold);
        exp_t  e;
        stim_t s;
        int    len;
        int    outcome;
        int    npad;
        len     = 0;
        outcome = 0;
        if (after_end) begin
            for (int i = 1; i < IFG; i++) begin
                push(rnd_stim(hold ? 1'b1 : 1'($urandom), 1'($urandom)), quiet());
            end
        end
        for (int i = 0; i < n_idle; i++) begin
            if ($urandom_range(1, 0) == 1) push(rnd_stim(1'b0, 1'($urandom)), quiet());
            else push(rnd_stim(1'b1, 1'b0), quiet());
        end
        push(rnd_stim(1'b1, 1'b1), quiet());
        e     = '0;
        e.ack = 1'b1;
        e.pre = 1'b1;
        push(rnd_stim(1'($urandom), 1'($urandom)), e);
        for (int i = 0; i < words.size() && outcome == 0; i++) begin
            s       = rnd_stim(1'($urandom), 1'($urandom));
            s.valid = words[i][7:0];
            s.eop   = words[i][8];
            e       = '0;
            e.dat   = 1'b1;
            e.len   = 14'(len);
            push(s, e);
            len += $countones(s.valid);
            if (s.valid == 8'h00 || len > MAX_B) outcome = 2;
            else if (s.eop && len < MIN_B) outcome = PAD_ON ? 3 : 2;
            else if (s.eop) outcome = 1;
        end
        if (outcome == 3) begin
            npad = (MIN_B - len + 7) / 8;
            for (int k = 0; k < npad; k++) begin
                e     = '0;
                e.pad = 1'b1;
                e.len = 14'(len + 8 * k);
                push(rnd_stim(1'($urandom), 1'($urandom)), e);
            end
            len     = MIN_B;
            outcome = 1;
        end
        e     = '0;
        e.len = 14'(len);
        if (outcome == 1) begin
            e.fcs = 1'b1;
            push(rnd_stim(1'($urandom), 1'($urandom)), e);
            e.fcs  = 1'b0;
            e.term = 1'b1;
            push(rnd_stim(1'($urandom), 1'($urandom)), e);
            pending = 1;
        end else begin
            e.err = 1'b1;
            push(rnd_stim(1'($urandom), 1'($urandom)), e);
            pending = 2;
        end
        prev_len  = 14'(len);
        after_end = 1'b1;
    endfunction

    function automatic void add_tail();
        for (int i = 0; i < IFG + 2; i++) begin
            push(rnd_stim(1'b0, 1'($urandom)), quiet());
        end
    endfunction

    task automatic run(input int limit);
        int n;
        n = 0;
        while (sq.size() > 0 && (limit < 0 || n < limit)) begin
            stim_t s;
            exp_t  e;
            s = sq.pop_front();
            e = eq.pop_front();
            @(negedge txclk);
            chk($sformatf("cycle %0d", cyc), {9'd0, obs_now}, {9'd0, e});
            tx_start      = s.start;
            tx_enable     = s.enable;
            tx_data_valid = s.valid;
            tx_eop        = s.eop;
            cyc++;
            n++;
        end
    endtask

    initial begin
        int kind;
        int nb;
        int idx;
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        pending       = 0;
        prev_len      = 14'd0;
        after_end     = 1'b0;
        reset         = 1'b1;
        tx_start      = 1'b0;
        tx_enable     = 1'b0;
        tx_data_valid = 8'h00;
        tx_eop        = 1'b0;
        @(negedge txclk);
        chk("reset outputs", {9'd0, obs_now}, 32'd0);
        @(negedge txclk);
        reset = 1'b0;

        gen_words(60, 1'b1);
        add_frame(1, 1'b0);
        gen_words(20, 1'b1);
        add_frame(0, 1'b0);
        gen_words(64, 1'b1);
        words[2] = words[2] & 9'h100;
        add_frame(1, 1'b0);
        gen_words(1520, 1'b0);
        add_frame(0, 1'b0);
        gen_words(MAX_B, 1'b1);
        add_frame(0, 1'b1);
        gen_words(MAX_B + 1, 1'b1);
        add_frame(0, 1'b1);
        gen_words(33, 1'b1);
        add_frame(0, 1'b1);
        gen_words(48, 1'b1);
        add_frame(0, 1'b1);

        for (int f = 0; f < 30; f++) begin
            kind = $urandom_range(9, 0);
            nb   = ($urandom_range(7, 0) == 0) ? $urandom_range(1520, 1400)
                                               : $urandom_range(130, 1);
            if (kind < 6) begin
                gen_words(nb, 1'b1);
            end else if (kind < 9) begin
                gen_words(nb, 1'b1);
                idx        = $urandom_range(words.size() - 1, 0);
                words[idx] = words[idx] & 9'h100;
            end else begin
                gen_words(1520, 1'b0);
            end
            add_frame($urandom_range(2, 0), 1'($urandom));
        end
        add_tail();
        run(-1);

        // Reset in the middle of DATA, then a clean frame afterwards.
        after_end = 1'b0;
        gen_words(64, 1'b1);
        add_frame(0, 1'b0);
        run(5);
        @(posedge txclk);
        #2 reset = 1'b1;
        #1 chk("reset mid-frame", {9'd0, obs_now}, 32'd0);
        sq.delete();
        eq.delete();
        pending   = 0;
        prev_len  = 14'd0;
        after_end = 1'b0;
        repeat (2) @(negedge txclk);
        tx_start      = 1'b0;
        tx_enable     = 1'b0;
        tx_data_valid = 8'h00;
        tx_eop        = 1'b0;
        reset         = 1'b0;
        for (int i = 0; i < 3; i++) push(rnd_stim(1'b0, 1'($urandom)), quiet());
        gen_words(40, 1'b1);
        add_frame(0, 1'b0);
        gen_words(72, 1'b1);
        add_frame(1, 1'b1);
        add_tail();
        run(-1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
